// File: rtl/audio_mem_pkg.sv
// Shared constants for the audio memory responder and the IO-side code that talks to it:
// FSM encoding, default access timing, bus widths and the IO mailbox addresses.
package audio_mem_pkg;

    localparam int unsigned AUDIO_ADDR_W      = 23;
    localparam int unsigned AUDIO_REQ_ADDR_W  = 24;
    localparam int unsigned AUDIO_DATA_W      = 16;
    localparam int unsigned AUDIO_TIMER_W     = 4;
    localparam int unsigned AUDIO_WAIT_CYCLES = 7;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_ACCESS  = 3'd2;
    localparam logic [2:0] ST_DONE    = 3'd3;
    localparam logic [2:0] ST_RECOVER = 3'd4;

    localparam logic [13:0] MBOX_BUTTON    = 14'h3FFC;
    localparam logic [13:0] MBOX_DONE_FLAG = 14'h3FFE;
    localparam logic [13:0] MBOX_COMMAND   = 14'h3FFF;

    typedef logic [AUDIO_DATA_W-1:0] audio_word_t;

endpackage

// File: rtl/audio_mem_wait_timer.sv
// Loadable down-counter that times the strobe-low window of one PSRAM access.
// o_tc is high while the count sits at zero; decrementing stops there.
module audio_mem_wait_timer
    import audio_mem_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_load,
    input  logic [AUDIO_TIMER_W-1:0] i_load_val,
    input  logic                     i_dec,
    output logic                     o_tc
);

    logic [AUDIO_TIMER_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_tc = (r_count == '0);

endmodule

// File: rtl/audio_mem_responder.sv
// Audio request responder: turns each level-held request into one timed async PSRAM access.
// Optional AUDIO_MEM_RANGE_GUARD_EN: addresses above DEPTH_WORDS complete without touching memory.
module audio_mem_responder
    import audio_mem_pkg::*;
#(
    parameter int unsigned       WAIT_CYCLES = AUDIO_WAIT_CYCLES,
    parameter int unsigned       ADDR_W      = AUDIO_ADDR_W,
    parameter logic [ADDR_W-1:0] DEPTH_WORDS = ADDR_W'(23'h7FFFFF)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        audio_req,
    input  logic [AUDIO_REQ_ADDR_W-1:0] audio_addr,
    input  logic                        audio_we,
    input  logic [AUDIO_DATA_W-1:0]     audio_wdata,
    output logic [AUDIO_DATA_W-1:0]     audio_rdata,
    output logic                        audio_data_ready,
    output logic                        busy,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [AUDIO_DATA_W-1:0]     mem_dq_o,
    input  logic [AUDIO_DATA_W-1:0]     mem_dq_i,
    output logic                        mem_dq_oe,
    output logic                        mem_ce_n,
    output logic                        mem_oe_n,
    output logic                        mem_we_n,
    output logic                        mem_ub_n,
    output logic                        mem_lb_n,
    output logic                        mem_adv_n,
    output logic                        mem_clk,
    output logic                        mem_cre
`ifdef AUDIO_MEM_RANGE_GUARD_EN
    ,
    output logic                        oor_err
`endif
);

    localparam logic [AUDIO_TIMER_W-1:0] LP_LOAD = AUDIO_TIMER_W'(WAIT_CYCLES - 1);

    logic [2:0]              r_state;
    logic                    r_we;
    logic [ADDR_W-1:0]       r_mem_addr;
    audio_word_t             r_dq_o;
    audio_word_t             r_rdata;
    logic                    r_dq_oe;
    logic                    r_ce_n;
    logic                    r_oe_n;
    logic                    r_we_n;
    logic                    r_bytes_n;
    logic                    r_data_ready;
    logic                    r_busy;
    logic                    w_tc;
    logic                    w_skip;

`ifdef AUDIO_MEM_RANGE_GUARD_EN
    logic                    r_oor_err;

    assign w_skip = (audio_addr > AUDIO_REQ_ADDR_W'(DEPTH_WORDS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_oor_err <= 1'b0;
        end else if ((r_state == ST_IDLE) && audio_req && w_skip) begin
            r_oor_err <= 1'b1;
        end
    end

    assign oor_err = r_oor_err;
`else
    logic                    w_unused_addr_hi;

    assign w_skip           = 1'b0;
    assign w_unused_addr_hi = ^{audio_addr[AUDIO_REQ_ADDR_W-1:ADDR_W], DEPTH_WORDS};
`endif

    audio_mem_wait_timer u_wait_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (r_state == ST_SETUP),
        .i_load_val (LP_LOAD),
        .i_dec      (r_state == ST_ACCESS),
        .o_tc       (w_tc)
    );

    // Outputs are registered with the values of the state being entered, so the
    // pins already show SETUP/ACCESS/DONE/RECOVER behaviour during that state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_we         <= 1'b0;
            r_mem_addr   <= '0;
            r_dq_o       <= '0;
            r_rdata      <= '0;
            r_dq_oe      <= 1'b0;
            r_ce_n       <= 1'b1;
            r_oe_n       <= 1'b1;
            r_we_n       <= 1'b1;
            r_bytes_n    <= 1'b1;
            r_data_ready <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_data_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (audio_req) begin
                        r_we   <= audio_we;
                        r_busy <= 1'b1;
                        if (w_skip) begin
                            r_state      <= ST_DONE;
                            r_data_ready <= 1'b1;
                            if (!audio_we) begin
                                r_rdata <= '0;
                            end
                        end else begin
                            r_state    <= ST_SETUP;
                            r_mem_addr <= audio_addr[ADDR_W-1:0];
                            r_ce_n     <= 1'b0;
                            r_bytes_n  <= 1'b0;
                            if (audio_we) begin
                                r_dq_o  <= audio_wdata;
                                r_dq_oe <= 1'b1;
                            end
                        end
                    end
                end
                ST_SETUP: begin
                    r_state <= ST_ACCESS;
                    if (r_we) begin
                        r_we_n <= 1'b0;
                    end else begin
                        r_oe_n <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    if (w_tc) begin
                        r_state      <= ST_DONE;
                        r_oe_n       <= 1'b1;
                        r_we_n       <= 1'b1;
                        r_data_ready <= 1'b1;
                        if (!r_we) begin
                            r_rdata <= mem_dq_i;
                        end
                    end
                end
                ST_DONE: begin
                    r_state   <= ST_RECOVER;
                    r_ce_n    <= 1'b1;
                    r_bytes_n <= 1'b1;
                    r_dq_oe   <= 1'b0;
                end
                ST_RECOVER: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_busy    <= 1'b0;
                    r_ce_n    <= 1'b1;
                    r_oe_n    <= 1'b1;
                    r_we_n    <= 1'b1;
                    r_bytes_n <= 1'b1;
                    r_dq_oe   <= 1'b0;
                end
            endcase
        end
    end

    assign audio_rdata      = r_rdata;
    assign audio_data_ready = r_data_ready;
    assign busy             = r_busy;
    assign mem_addr         = r_mem_addr;
    assign mem_dq_o         = r_dq_o;
    assign mem_dq_oe        = r_dq_oe;
    assign mem_ce_n         = r_ce_n;
    assign mem_oe_n         = r_oe_n;
    assign mem_we_n         = r_we_n;
    assign mem_ub_n         = r_bytes_n;
    assign mem_lb_n         = r_bytes_n;
    assign mem_adv_n        = 1'b0;
    assign mem_clk          = 1'b0;
    assign mem_cre          = 1'b0;

endmodule
